// File: rtl/change_dispenser.sv
// Purpose: computes change owed on a vend and pays it out greedily, one coin at a time, from per-denomination inventories.
// Latency: vend_req edge to first coin_valid is 3 cycles; one coin per 2 cycles with hop_ready high; zero change gives done 3 cycles after vend_req.
// Backpressure: coin_valid/coin_sel hold until hop_ready; inventory and owed change only on a transfer. Optional macro CHANGE_DOLLAR_EN adds dollar coins.
module change_dispenser #(
    parameter int WIDTH    = 11,
    parameter int INV_W    = 6,
    parameter int INV_INIT = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vend_req,
    input  logic [WIDTH-1:0] price,
    input  logic [WIDTH-1:0] paid,
    input  logic             credit,
    input  logic             refill,
    input  logic             hop_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [WIDTH-1:0] owed
);

`ifdef CHANGE_DOLLAR_EN
    localparam int NDEN = 4;
`else
    localparam int NDEN = 3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SELECT,
        S_ISSUE,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   price_q, price_d;
    logic [WIDTH-1:0]   paid_q, paid_d;
    logic               credit_q, credit_d;
    logic [WIDTH-1:0]   owed_q, owed_d;
    logic               short_q, short_d;
    logic [1:0]         coin_sel_q, coin_sel_d;
    logic [INV_W-1:0]   inv_q [NDEN];
    logic [INV_W-1:0]   inv_d [NDEN];

    logic               pick_ok;
    logic [1:0]         pick_sel;

    // Face value in cents of each coin code.
    function automatic logic [WIDTH-1:0] coin_val(input logic [1:0] sel);
        case (sel)
            2'd0:    coin_val = WIDTH'(5);
            2'd1:    coin_val = WIDTH'(10);
            2'd2:    coin_val = WIDTH'(25);
            default: coin_val = WIDTH'(100);
        endcase
    endfunction

    // Greedy pick: ascending scan so the largest affordable, stocked coin wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_sel = 2'd0;
        for (int i = 0; i < NDEN; i++) begin
            if (inv_q[i] != '0 && coin_val(2'(i)) <= owed_q) begin
                pick_ok  = 1'b1;
                pick_sel = 2'(i);
            end
        end
    end

    // Next-state and datapath updates for the dispense sequence.
    always_comb begin
        state_d    = state_q;
        price_d    = price_q;
        paid_d     = paid_q;
        credit_d   = credit_q;
        owed_d     = owed_q;
        short_d    = short_q;
        coin_sel_d = coin_sel_q;
        inv_d      = inv_q;
        case (state_q)
            S_IDLE: begin
                // A vend in the same cycle as a refill drops the refill.
                if (vend_req) begin
                    price_d  = price;
                    paid_d   = paid;
                    credit_d = credit;
                    short_d  = 1'b0;
                    state_d  = S_CALC;
                end else if (refill) begin
                    for (int i = 0; i < NDEN; i++) begin
                        inv_d[i] = INV_W'(INV_INIT);
                    end
                end
            end
            S_CALC: begin
                owed_d  = (!credit_q && paid_q > price_q) ? (paid_q - price_q) : '0;
                state_d = S_SELECT;
            end
            S_SELECT: begin
                if (owed_q == '0) begin
                    state_d = S_FINISH;
                end else if (pick_ok) begin
                    coin_sel_d = pick_sel;
                    state_d    = S_ISSUE;
                end else begin
                    short_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_ISSUE: begin
                // Only a completed handshake consumes a coin.
                if (hop_ready) begin
                    owed_d = owed_q - coin_val(coin_sel_q);
                    for (int i = 0; i < NDEN; i++) begin
                        if (coin_sel_q == 2'(i) && inv_q[i] != '0) begin
                            inv_d[i] = inv_q[i] - INV_W'(1);
                        end
                    end
                    state_d = S_SELECT;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            price_q    <= '0;
            paid_q     <= '0;
            credit_q   <= 1'b0;
            owed_q     <= '0;
            short_q    <= 1'b0;
            coin_sel_q <= 2'd0;
            for (int i = 0; i < NDEN; i++) begin
                inv_q[i] <= INV_W'(INV_INIT);
            end
        end else begin
            state_q    <= state_d;
            price_q    <= price_d;
            paid_q     <= paid_d;
            credit_q   <= credit_d;
            owed_q     <= owed_d;
            short_q    <= short_d;
            coin_sel_q <= coin_sel_d;
            inv_q      <= inv_d;
        end
    end

    assign coin_valid = (state_q == S_ISSUE);
    assign coin_sel   = coin_sel_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);
    assign short      = short_q;
    assign owed       = owed_q;

endmodule
